mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage, directly downstream of the execute stage. It registers the execute results, performs loads and stores against a word-addressed data memory using a req/ack handshake, and stalls upstream while a memory access is outstanding. It presents writeback data and destination register to the writeback stage, and forwards the branch decision and target.

Parameters:
ADDR_W, 10, data-memory word-address width
TIMEOUT, 16, max cycles waiting for Mem_Ack before aborting the access (>=2)

Ports:
Clk  input  1  clock, rising edge
Reset_n  input  1  reset; reset is asynchronous and active-low
Valid_In  input  1  execute-stage outputs are valid this cycle
Inst_In  input  32  instruction from execute
Inst_Type_In  input  5  opcode class from execute
Result_In  input  32  ALU result / effective address / branch target
Operand_B_In  input  32  store data
isBranchTaken_In  input  1  branch decision from execute
Stall_Out  output  1  upstream must hold inputs
Mem_Req  output  1  memory request
Mem_We  output  1  1 = write
Mem_Addr  output  ADDR_W  word address
Mem_Wdata  output  32  write data
Mem_Rdata  input  32  read data, valid with Mem_Ack
Mem_Ack  input  1  access complete
WB_Valid_Out  output  1  one-cycle pulse, instruction retired to writeback
WB_En_Out  output  1  register write enable
WB_Rd_Out  output  5  destination register Inst[11:7]
WB_Data_Out  output  32  writeback data
Inst_Out  output  32  retired instruction
Inst_Type_Out  output  5  retired opcode class
Branch_Taken_Out  output  1  one-cycle pulse with WB_Valid_Out
Branch_Target_Out  output  32  registered Result_In of the taken branch
Mem_Err_Out  output  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Opcode classes: IMM 00100, REG 01100, LOAD 00000, STORE 01000, BRANCH 11000, MAC 11111. Any other class retires as a no-op.
- Reset: FSM goes to IDLE. Every output is 0 and the timeout counter is cleared. Reset asserted mid-access drops Mem_Req immediately, with no retire and no error.
- FSM states: IDLE, ACCESS, RETIRE.
- IDLE: Stall_Out=0. On Valid_In, capture all inputs.
  - LOAD/STORE with Result_In[1:0]==0: go to ACCESS.
  - Any other capture: go to RETIRE.
- ACCESS:
  - Mem_Req=1, Mem_We=(STORE), Mem_Addr=Result[ADDR_W+1:2], Mem_Wdata=Operand_B. These values are held stable until the cycle Mem_Ack is sampled high.
  - On Mem_Ack: latch Mem_Rdata (LOAD) and go to RETIRE. The next cycle has Mem_Req=0.
  - The counter increments each cycle in ACCESS. If it reaches TIMEOUT-1 without Mem_Ack, drop Mem_Req, set an error flag and go to RETIRE.
- RETIRE: outputs are valid for exactly one cycle, then return to IDLE.
  - WB_Valid_Out=1.
  - WB_Data_Out: load data for LOAD, otherwise Result.
  - WB_En_Out=1 only for IMM/REG/LOAD with rd!=0 and no error. It is 0 for STORE, BRANCH, MAC, unknown and error cases.
  - Branch_Taken_Out = (BRANCH && captured isBranchTaken). Branch_Target_Out = Result. Branch_Target_Out holds its value otherwise.
  - Mem_Err_Out=1 on timeout or misaligned LOAD/STORE (Result[1:0]!=0). A misaligned access never issues Mem_Req.
- Stall_Out = (state != IDLE), combinational from state. Upstream holds while it is high. Valid_In is ignored outside IDLE.
- Latency:
  - Non-memory op accepted at edge N retires at cycle N+1.
  - Memory op accepted at N: Mem_Req is high from N+1. With Mem_Ack at cycle M, it retires at M+1.
  - Throughput is therefore one instruction per 2 cycles for non-memory ops.
- Mem_Ack sampled while not in ACCESS is ignored.
- Outputs other than WB_Valid_Out, Branch_Taken_Out and Mem_Err_Out hold their last values between retires.

Test Plan:
- Reset during ACCESS (Mem_Req=1), Reset_n low asynchronously mid-cycle -> Mem_Req=0, Stall_Out=0, WB_Valid_Out=0 immediately; no retire after release.
- REG op, Inst rd=5, Result_In=0x0000_0007, Valid_In=1 at edge N -> at N+1 WB_Valid_Out=1, WB_En_Out=1, WB_Rd_Out=5, WB_Data_Out=0x7; Mem_Req stays 0.
- LOAD, Result_In=0x0000_0010, rd=3, Mem_Ack after 3 cycles with Mem_Rdata=0xDEADBEEF -> Mem_Addr=4, Mem_We=0, Stall_Out high throughout; one cycle after ack WB_Data_Out=0xDEADBEEF, WB_En_Out=1, WB_Rd_Out=3.
- STORE, Result_In=0x8, Operand_B_In=0x1234, Mem_Ack at first request cycle -> Mem_We=1, Mem_Addr=2, Mem_Wdata=0x1234; retire with WB_En_Out=0, Mem_Err_Out=0.
- LOAD, Result_In=0x6 (misaligned) -> no Mem_Req; retire next cycle with Mem_Err_Out=1, WB_En_Out=0.
- LOAD with Mem_Ack never asserted, TIMEOUT=16 -> Mem_Req high exactly 16 cycles, then Mem_Err_Out=1 at retire, WB_En_Out=0.
- BRANCH, isBranchTaken_In=1, Result_In=0x40 -> Branch_Taken_Out=1 for one cycle with Branch_Target_Out=0x40; with isBranchTaken_In=0 -> Branch_Taken_Out=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results, runs loads/stores over a
// req/ack data-memory port, stalls upstream while busy and retires to writeback.
module mem_stage #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Valid_In,
    input  logic [31:0]       Inst_In,
    input  logic [4:0]        Inst_Type_In,
    input  logic [31:0]       Result_In,
    input  logic [31:0]       Operand_B_In,
    input  logic              isBranchTaken_In,
    output logic              Stall_Out,
    output logic              Mem_Req,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_Wdata,
    input  logic [31:0]       Mem_Rdata,
    input  logic              Mem_Ack,
    output logic              WB_Valid_Out,
    output logic              WB_En_Out,
    output logic [4:0]        WB_Rd_Out,
    output logic [31:0]       WB_Data_Out,
    output logic [31:0]       Inst_Out,
    output logic [4:0]        Inst_Type_Out,
    output logic              Branch_Taken_Out,
    output logic [31:0]       Branch_Target_Out,
    output logic              Mem_Err_Out
);

    localparam logic [4:0] T_IMM    = 5'b00100;
    localparam logic [4:0] T_REG    = 5'b01100;
    localparam logic [4:0] T_LOAD   = 5'b00000;
    localparam logic [4:0] T_STORE  = 5'b01000;
    localparam logic [4:0] T_BRANCH = 5'b11000;
    localparam int         CW       = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RETIRE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     inst_q, inst_d;
    logic [4:0]      type_q, type_d;
    logic [31:0]     result_q, result_d;
    logic [31:0]     opb_q, opb_d;
    logic            taken_q, taken_d;

    logic            wb_en_q, wb_en_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic [31:0]     inst_out_q, inst_out_d;
    logic [4:0]      type_out_q, type_out_d;
    logic            br_taken_q, br_taken_d;
    logic [31:0]     br_target_q, br_target_d;
    logic            err_q, err_d;

    logic            from_idle;
    logic [31:0]     s_inst;
    logic [4:0]      s_type;
    logic [31:0]     s_result;
    logic            s_taken;
    logic            s_mem;
    logic            s_mis;
    logic            timeout_hit;
    logic            retire_go;
    logic            err_n;
    logic [31:0]     data_n;

    // Retire bundle comes straight from the inputs when retiring from IDLE,
    // otherwise from the instruction captured before the memory access.
    always_comb begin
        from_idle   = (state_q == IDLE);
        s_inst      = from_idle ? Inst_In          : inst_q;
        s_type      = from_idle ? Inst_Type_In     : type_q;
        s_result    = from_idle ? Result_In        : result_q;
        s_taken     = from_idle ? isBranchTaken_In : taken_q;
        s_mem       = (s_type == T_LOAD) || (s_type == T_STORE);
        s_mis       = (s_result[1:0] != 2'b00);
        timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        type_d      = type_q;
        result_d    = result_q;
        opb_d       = opb_q;
        taken_d     = taken_q;
        retire_go   = 1'b0;
        err_n       = 1'b0;
        data_n      = s_result;

        unique case (state_q)
            IDLE: begin
                if (Valid_In) begin
                    inst_d   = Inst_In;
                    type_d   = Inst_Type_In;
                    result_d = Result_In;
                    opb_d    = Operand_B_In;
                    taken_d  = isBranchTaken_In;
                    if (s_mem && !s_mis) begin
                        state_d = ACCESS;
                    end else begin
                        state_d   = RETIRE;
                        retire_go = 1'b1;
                        err_n     = s_mem;
                    end
                end
            end
            ACCESS: begin
                if (Mem_Ack) begin
                    state_d   = RETIRE;
                    retire_go = 1'b1;
                    if (type_q == T_LOAD) data_n = Mem_Rdata;
                end else if (timeout_hit) begin
                    state_d   = RETIRE;
                    retire_go = 1'b1;
                    err_n     = 1'b1;
                end
            end
            RETIRE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = ((state_q == ACCESS) && (state_d == ACCESS)) ?
                cnt_q + 1'b1 : '0;
    end

    always_comb begin
        wb_en_d     = wb_en_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        inst_out_d  = inst_out_q;
        type_out_d  = type_out_q;
        br_target_d = br_target_q;
        br_taken_d  = 1'b0;
        err_d       = 1'b0;
        if (retire_go) begin
            inst_out_d = s_inst;
            type_out_d = s_type;
            wb_rd_d    = s_inst[11:7];
            wb_data_d  = data_n;
            wb_en_d    = ((s_type == T_IMM) || (s_type == T_REG) ||
                          (s_type == T_LOAD)) &&
                         (s_inst[11:7] != 5'd0) && !err_n;
            br_taken_d = (s_type == T_BRANCH) && s_taken;
            if (br_taken_d) br_target_d = s_result;
            err_d      = err_n;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            inst_q      <= '0;
            type_q      <= '0;
            result_q    <= '0;
            opb_q       <= '0;
            taken_q     <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            inst_out_q  <= '0;
            type_out_q  <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inst_q      <= inst_d;
            type_q      <= type_d;
            result_q    <= result_d;
            opb_q       <= opb_d;
            taken_q     <= taken_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            inst_out_q  <= inst_out_d;
            type_out_q  <= type_out_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            err_q       <= err_d;
        end
    end

    assign Stall_Out         = (state_q != IDLE);
    assign Mem_Req           = (state_q == ACCESS);
    assign Mem_We            = (state_q == ACCESS) && (type_q == T_STORE);
    assign Mem_Addr          = result_q[ADDR_W+1:2];
    assign Mem_Wdata         = opb_q;
    assign WB_Valid_Out      = (state_q == RETIRE);
    assign WB_En_Out         = wb_en_q;
    assign WB_Rd_Out         = wb_rd_q;
    assign WB_Data_Out       = wb_data_q;
    assign Inst_Out          = inst_out_q;
    assign Inst_Type_Out     = type_out_q;
    assign Branch_Taken_Out  = br_taken_q;
    assign Branch_Target_Out = br_target_q;
    assign Mem_Err_Out       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized ops checked
// against a behavioural retire model.
module tb_mem_stage;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;
    localparam logic [4:0] T_IMM    = 5'b00100;
    localparam logic [4:0] T_REG    = 5'b01100;
    localparam logic [4:0] T_LOAD   = 5'b00000;
    localparam logic [4:0] T_STORE  = 5'b01000;
    localparam logic [4:0] T_BRANCH = 5'b11000;
    localparam logic [4:0] T_MAC    = 5'b11111;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Valid_In;
    logic [31:0]       Inst_In;
    logic [4:0]        Inst_Type_In;
    logic [31:0]       Result_In;
    logic [31:0]       Operand_B_In;
    logic              isBranchTaken_In;
    logic              Stall_Out;
    logic              Mem_Req;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_Wdata;
    logic [31:0]       Mem_Rdata;
    logic              Mem_Ack;
    logic              WB_Valid_Out;
    logic              WB_En_Out;
    logic [4:0]        WB_Rd_Out;
    logic [31:0]       WB_Data_Out;
    logic [31:0]       Inst_Out;
    logic [4:0]        Inst_Type_Out;
    logic              Branch_Taken_Out;
    logic [31:0]       Branch_Target_Out;
    logic              Mem_Err_Out;

    mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Valid_In(Valid_In),
        .Inst_In(Inst_In), .Inst_Type_In(Inst_Type_In),
        .Result_In(Result_In), .Operand_B_In(Operand_B_In),
        .isBranchTaken_In(isBranchTaken_In), .Stall_Out(Stall_Out),
        .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack),
        .WB_Valid_Out(WB_Valid_Out), .WB_En_Out(WB_En_Out),
        .WB_Rd_Out(WB_Rd_Out), .WB_Data_Out(WB_Data_Out),
        .Inst_Out(Inst_Out), .Inst_Type_Out(Inst_Type_Out),
        .Branch_Taken_Out(Branch_Taken_Out),
        .Branch_Target_Out(Branch_Target_Out), .Mem_Err_Out(Mem_Err_Out)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_target;

    typedef struct {
        int req_cycles;
        logic idle_ok, stall_ok, stable, we;
        logic [ADDR_W-1:0] addr;
        logic [31:0] wdata;
        logic valid, en;
        logic [4:0] rd;
        logic [31:0] data, inst;
        logic [4:0] ty;
        logic taken;
        logic [31:0] target;
        logic err, req_ret;
        logic valid_after, taken_after, err_after, stall_after;
        logic [4:0] rd_after;
    } obs_t;

    typedef struct {
        int req_cycles;
        logic acc, we;
        logic [ADDR_W-1:0] addr;
        logic en;
        logic [31:0] data;
        logic taken;
        logic [31:0] target;
        logic err;
    } exp_t;

    // What the retire stage must show, from the opcode-class rules alone.
    function automatic exp_t model(input logic [4:0] ty, input logic [31:0] inst,
                                   input logic [31:0] res, input int ack_dly,
                                   input logic tk, input logic [31:0] rdata,
                                   input logic [31:0] prev_target);
        exp_t e;
        logic is_mem, mis, tout;
        is_mem = (ty == T_LOAD) || (ty == T_STORE);
        mis    = (res % 4) != 0;
        e.acc  = is_mem && !mis;
        tout   = e.acc && (ack_dly < 0 || ack_dly >= TIMEOUT);
        e.req_cycles = !e.acc ? 0 : (tout ? TIMEOUT : ack_dly + 1);
        e.err  = (is_mem && mis) || tout;
        e.we   = (ty == T_STORE);
        e.addr = ADDR_W'(res / 4);
        e.en   = (ty == T_IMM || ty == T_REG || ty == T_LOAD) &&
                 inst[11:7] != 0 && !e.err;
        e.data = (ty == T_LOAD && e.acc && !tout) ? rdata : res;
        e.taken  = (ty == T_BRANCH) && tk;
        e.target = e.taken ? res : prev_target;
        return e;
    endfunction

    function automatic logic [31:0] mk_inst(input logic [4:0] rd);
        logic [31:0] x;
        x = $urandom;
        x[11:7] = rd;
        return x;
    endfunction

    // Issue one op from a negedge in IDLE, serve the memory port, and record
    // what the DUT showed. Ends on the negedge of the cycle after retire.
    task automatic run_op(input logic [4:0] ty, input logic [31:0] inst,
                          input logic [31:0] res, input logic [31:0] opb,
                          input logic tk, input int ack_dly,
                          input logic [31:0] rdata, output obs_t o);
        int n;
        o.idle_ok = (Stall_Out === 1'b0);
        Valid_In = 1'b1; Inst_In = inst; Inst_Type_In = ty;
        Result_In = res; Operand_B_In = opb; isBranchTaken_In = tk;
        Mem_Ack = 1'($urandom % 2); Mem_Rdata = $urandom;
        @(negedge Clk);
        Valid_In = 1'($urandom % 2); Inst_In = $urandom;
        Inst_Type_In = 5'($urandom); Result_In = $urandom;
        Operand_B_In = $urandom; isBranchTaken_In = 1'($urandom % 2);
        Mem_Ack = 1'b0;
        n = 0; o.stall_ok = 1'b1; o.stable = 1'b1;
        o.we = Mem_We; o.addr = Mem_Addr; o.wdata = Mem_Wdata;
        while (Mem_Req === 1'b1 && n < TIMEOUT + 4) begin
            if (Mem_We !== o.we || Mem_Addr !== o.addr || Mem_Wdata !== o.wdata)
                o.stable = 1'b0;
            if (Stall_Out !== 1'b1) o.stall_ok = 1'b0;
            if (n == ack_dly) begin Mem_Ack = 1'b1; Mem_Rdata = rdata; end
            @(negedge Clk);
            Mem_Ack = 1'b0; Mem_Rdata = $urandom;
            n++;
        end
        o.req_cycles = n;
        if (Stall_Out !== 1'b1) o.stall_ok = 1'b0;
        o.valid = WB_Valid_Out; o.en = WB_En_Out; o.rd = WB_Rd_Out;
        o.data = WB_Data_Out; o.inst = Inst_Out; o.ty = Inst_Type_Out;
        o.taken = Branch_Taken_Out; o.target = Branch_Target_Out;
        o.err = Mem_Err_Out; o.req_ret = Mem_Req;
        Valid_In = 1'b0;
        @(negedge Clk);
        o.valid_after = WB_Valid_Out; o.taken_after = Branch_Taken_Out;
        o.err_after = Mem_Err_Out; o.stall_after = Stall_Out;
        o.rd_after = WB_Rd_Out;
    endtask

    task automatic test_reset();
        logic [212:0] all_out;
        Reset_n = 1'b0; Valid_In = 1'b0; Inst_In = '0; Inst_Type_In = '0;
        Result_In = '0; Operand_B_In = '0; isBranchTaken_In = 1'b0;
        Mem_Rdata = '0; Mem_Ack = 1'b0;
        last_target = '0;
        #12;
        all_out = {Stall_Out, Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
                   WB_Valid_Out, WB_En_Out, WB_Rd_Out, WB_Data_Out, Inst_Out,
                   Inst_Type_Out, Branch_Taken_Out, Branch_Target_Out,
                   Mem_Err_Out, 13'h0};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_reg_op();
        obs_t o;
        run_op(T_REG, mk_inst(5'd5), 32'h7, $urandom, 1'b0, 0, $urandom, o);
        checks++;
        if ({o.valid, o.en, o.rd} !== {1'b1, 1'b1, 5'd5}) begin
            failures++;
            $display("FAIL reg_retire: got v=%b en=%b rd=%0d want 1 1 5",
                     o.valid, o.en, o.rd);
        end
        checks++;
        if (o.data !== 32'h7) begin
            failures++;
            $display("FAIL reg_data: got %h want 7", o.data);
        end
        checks++;
        if (o.req_cycles !== 0 || o.req_ret !== 1'b0) begin
            failures++;
            $display("FAIL reg_no_req: got %0d req cycles want 0", o.req_cycles);
        end
    endtask

    task automatic test_load();
        obs_t o;
        run_op(T_LOAD, mk_inst(5'd3), 32'h10, $urandom, 1'b0, 3,
               32'hDEADBEEF, o);
        checks++;
        if ({o.addr, o.we, o.stall_ok, o.stable} !== {10'd4, 1'b0, 1'b1, 1'b1})
        begin
            failures++;
            $display("FAIL load_req: got addr=%0d we=%b stall=%b stable=%b want 4 0 1 1",
                     o.addr, o.we, o.stall_ok, o.stable);
        end
        checks++;
        if (o.req_cycles !== 4) begin
            failures++;
            $display("FAIL load_latency: got %0d req cycles want 4", o.req_cycles);
        end
        checks++;
        if ({o.valid, o.en, o.rd, o.data} !== {1'b1, 1'b1, 5'd3, 32'hDEADBEEF})
        begin
            failures++;
            $display("FAIL load_retire: got v=%b en=%b rd=%0d data=%h want 1 1 3 deadbeef",
                     o.valid, o.en, o.rd, o.data);
        end
    endtask

    task automatic test_store();
        obs_t o;
        run_op(T_STORE, mk_inst(5'd9), 32'h8, 32'h1234, 1'b0, 0, $urandom, o);
        checks++;
        if ({o.we, o.addr, o.wdata} !== {1'b1, 10'd2, 32'h1234}) begin
            failures++;
            $display("FAIL store_req: got we=%b addr=%0d wdata=%h want 1 2 1234",
                     o.we, o.addr, o.wdata);
        end
        checks++;
        if ({o.req_cycles == 1, o.valid, o.en, o.err} !== 4'b1100) begin
            failures++;
            $display("FAIL store_retire: got req=%0d v=%b en=%b err=%b want 1 1 0 0",
                     o.req_cycles, o.valid, o.en, o.err);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_op(T_LOAD, mk_inst(5'd7), 32'h6, $urandom, 1'b0, 0, $urandom, o);
        checks++;
        if ({o.req_cycles == 0, o.valid, o.err, o.en} !== 4'b1110) begin
            failures++;
            $display("FAIL misaligned: got req=%0d v=%b err=%b en=%b want 0 1 1 0",
                     o.req_cycles, o.valid, o.err, o.en);
        end
        checks++;
        if (o.err_after !== 1'b0 || o.valid_after !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_pulse: got err=%b v=%b after retire want 0 0",
                     o.err_after, o.valid_after);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_op(T_LOAD, mk_inst(5'd4), 32'h20, $urandom, 1'b0, -1, $urandom, o);
        checks++;
        if (o.req_cycles !== TIMEOUT) begin
            failures++;
            $display("FAIL timeout_len: got %0d req cycles want %0d",
                     o.req_cycles, TIMEOUT);
        end
        checks++;
        if ({o.valid, o.err, o.en} !== 3'b110) begin
            failures++;
            $display("FAIL timeout_retire: got v=%b err=%b en=%b want 1 1 0",
                     o.valid, o.err, o.en);
        end
    endtask

    task automatic test_branch();
        obs_t o;
        run_op(T_BRANCH, mk_inst(5'd1), 32'h40, $urandom, 1'b1, 0, $urandom, o);
        checks++;
        if ({o.taken, o.target, o.taken_after, o.en} !== {1'b1, 32'h40, 1'b0, 1'b0})
        begin
            failures++;
            $display("FAIL branch_taken: got t=%b tgt=%h next=%b en=%b want 1 40 0 0",
                     o.taken, o.target, o.taken_after, o.en);
        end
        last_target = 32'h40;
        run_op(T_BRANCH, mk_inst(5'd1), 32'h80, $urandom, 1'b0, 0, $urandom, o);
        checks++;
        if ({o.valid, o.taken, o.target} !== {1'b1, 1'b0, 32'h40}) begin
            failures++;
            $display("FAIL branch_not_taken: got v=%b t=%b tgt=%h want 1 0 40",
                     o.valid, o.taken, o.target);
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic [4:0] ty, tys[6];
        logic [31:0] inst, res, rdata;
        logic tk;
        int ack;
        tys = '{T_IMM, T_REG, T_LOAD, T_STORE, T_BRANCH, T_MAC};
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 6) == 6) begin
                do ty = 5'($urandom);
                while (ty inside {T_IMM, T_REG, T_LOAD, T_STORE, T_BRANCH, T_MAC});
            end else begin
                ty = tys[$urandom_range(0, 5)];
            end
            inst = mk_inst(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
            res = $urandom;
            if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
            tk = 1'($urandom % 2);
            rdata = $urandom;
            case ($urandom_range(0, 7))
                0: ack = -1;
                1, 2: ack = $urandom_range(0, TIMEOUT);
                default: ack = $urandom_range(0, 4);
            endcase
            e = model(ty, inst, res, ack, tk, rdata, last_target);
            run_op(ty, inst, res, $urandom, tk, ack, rdata, o);
            checks++;
            if (o.req_cycles !== e.req_cycles) begin
                failures++;
                $display("FAIL rnd%0d_req_cycles: got %0d want %0d", i,
                         o.req_cycles, e.req_cycles);
            end
            checks++;
            if ({o.valid, o.en, o.err, o.taken} !== {1'b1, e.en, e.err, e.taken})
            begin
                failures++;
                $display("FAIL rnd%0d_flags: got v/en/err/t=%b%b%b%b want 1%b%b%b",
                         i, o.valid, o.en, o.err, o.taken, e.en, e.err, e.taken);
            end
            checks++;
            if ({o.rd, o.inst, o.ty, o.target} !== {inst[11:7], inst, ty, e.target})
            begin
                failures++;
                $display("FAIL rnd%0d_fields: got rd=%0d inst=%h ty=%b tgt=%h want %0d %h %b %h",
                         i, o.rd, o.inst, o.ty, o.target, inst[11:7], inst, ty, e.target);
            end
            if (!e.err) begin
                checks++;
                if (o.data !== e.data) begin
                    failures++;
                    $display("FAIL rnd%0d_data: got %h want %h", i, o.data, e.data);
                end
            end
            if (e.acc) begin
                checks++;
                if ({o.we, o.addr, o.stable} !== {e.we, e.addr, 1'b1}) begin
                    failures++;
                    $display("FAIL rnd%0d_mem: got we=%b addr=%h stable=%b want %b %h 1",
                             i, o.we, o.addr, o.stable, e.we, e.addr);
                end
            end
            checks++;
            if ({o.idle_ok, o.stall_ok, o.valid_after, o.taken_after, o.err_after,
                 o.stall_after, o.rd_after} !== {6'b110000, inst[11:7]}) begin
                failures++;
                $display("FAIL rnd%0d_handshake: got idle=%b stall=%b after v/t/e/s=%b%b%b%b rd=%0d",
                         i, o.idle_ok, o.stall_ok, o.valid_after, o.taken_after,
                         o.err_after, o.stall_after, o.rd_after);
            end
            last_target = e.target;
        end
    endtask

    task automatic test_reset_mid_access();
        int seen;
        Valid_In = 1'b1; Inst_In = mk_inst(5'd2); Inst_Type_In = T_LOAD;
        Result_In = 32'h100; Operand_B_In = $urandom; isBranchTaken_In = 1'b0;
        @(negedge Clk);
        Valid_In = 1'b0;
        @(negedge Clk);
        checks++;
        if (Mem_Req !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: got Mem_Req=%b want 1", Mem_Req);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({Mem_Req, Stall_Out, WB_Valid_Out, Branch_Target_Out} !== 35'd0) begin
            failures++;
            $display("FAIL midrst_async: got req=%b stall=%b v=%b tgt=%h want 0",
                     Mem_Req, Stall_Out, WB_Valid_Out, Branch_Target_Out);
        end
        @(negedge Clk);
        Reset_n = 1'b1; Mem_Ack = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            Mem_Ack = 1'b0;
            if (WB_Valid_Out !== 1'b0 || Mem_Req !== 1'b0 || Mem_Err_Out !== 1'b0)
                seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midrst_no_retire: got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_reg_op();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_branch();
        test_random();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want finish before 200000");
        $fatal(1);
    end

endmodule
